// File: rtl/mini_cpu_pkg.sv
// Shared encodings for the mini CPU: opcodes, ALU select codes, FSM state
// encoding and instruction field positions.
package mini_cpu_pkg;

  localparam int INSTR_W  = 12;
  localparam int DATA_W   = 8;
  localparam int NUM_REGS = 4;

  localparam int OPC_HI    = 11;
  localparam int OPC_LO    = 10;
  localparam int SEL_HI    = 9;
  localparam int SEL_LO    = 8;
  localparam int ALU_RD_HI = 7;
  localparam int ALU_RD_LO = 6;
  localparam int RS1_HI    = 5;
  localparam int RS1_LO    = 4;
  localparam int RS2_HI    = 3;
  localparam int RS2_LO    = 2;
  localparam int LDI_RD_HI = 9;
  localparam int LDI_RD_LO = 8;
  localparam int IMM_HI    = 7;
  localparam int IMM_LO    = 0;
  localparam int TGT_HI    = 3;
  localparam int TGT_LO    = 0;

  typedef enum logic [1:0] {
    OP_ALU  = 2'b00,
    OP_LDI  = 2'b01,
    OP_BZ   = 2'b10,
    OP_HALT = 2'b11
  } opcode_t;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_sel_t;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_EXEC  = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  function automatic logic is_busy_state(input logic [2:0] s);
    return (s == S_FETCH) || (s == S_EXEC) || (s == S_WAIT);
  endfunction

endpackage

// File: rtl/mini_cpu_decode.sv
// Pure combinational instruction decode: splits an instruction word into its
// kind and operand fields.
module mini_cpu_decode
  import mini_cpu_pkg::*;
(
  input  logic [INSTR_W-1:0] ir,
  output opcode_t            kind,
  output alu_sel_t           sel,
  output logic [1:0]         rd,
  output logic [1:0]         rs1,
  output logic [1:0]         rs2,
  output logic [DATA_W-1:0]  imm,
  output logic [3:0]         target
);

  // LDI and ALU keep their destination in different fields, so rd is muxed on kind.
  always_comb begin
    kind   = opcode_t'(ir[OPC_HI:OPC_LO]);
    sel    = alu_sel_t'(ir[SEL_HI:SEL_LO]);
    rs1    = ir[RS1_HI:RS1_LO];
    rs2    = ir[RS2_HI:RS2_LO];
    imm    = ir[IMM_HI:IMM_LO];
    target = ir[TGT_HI:TGT_LO];
    rd     = ir[ALU_RD_HI:ALU_RD_LO];
    if (kind == OP_LDI) begin
      rd = ir[LDI_RD_HI:LDI_RD_LO];
    end
  end

endmodule

// File: rtl/mini_cpu_controller.sv
// Multi-cycle controller for a tiny 4-register CPU: FSM, register file and
// program memory, driving an external ALU of configurable latency.
module mini_cpu_controller
  import mini_cpu_pkg::*;
#(
  parameter int ALU_LATENCY = 1,
  parameter int PROG_DEPTH  = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          prog_we,
  input  logic [$clog2(PROG_DEPTH)-1:0] prog_addr,
  input  logic [INSTR_W-1:0]            prog_data,
  output logic [DATA_W-1:0]             alu_a,
  output logic [DATA_W-1:0]             alu_b,
  output logic [1:0]                    alu_sel,
  input  logic [DATA_W-1:0]             alu_result,
  input  logic                          alu_zero,
  input  logic                          alu_carry,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(PROG_DEPTH)-1:0] pc,
  output logic                          flag_z,
  output logic                          flag_c,
  input  logic [1:0]                    dbg_addr,
  output logic [DATA_W-1:0]             dbg_data
);

  localparam int PC_W = $clog2(PROG_DEPTH);
  localparam logic [1:0] WAIT_LAST = 2'(ALU_LATENCY - 1);

  logic [2:0]         state;
  logic [INSTR_W-1:0] ir;
  logic [1:0]         wait_cnt;
  logic [DATA_W-1:0]  regs [NUM_REGS];
  logic [INSTR_W-1:0] mem  [PROG_DEPTH];

  opcode_t           kind;
  alu_sel_t          sel;
  logic [1:0]        rd;
  logic [1:0]        rs1;
  logic [1:0]        rs2;
  logic [DATA_W-1:0] imm;
  logic [3:0]        target;

  mini_cpu_decode u_decode (
    .ir     (ir),
    .kind   (kind),
    .sel    (sel),
    .rd     (rd),
    .rs1    (rs1),
    .rs2    (rs2),
    .imm    (imm),
    .target (target)
  );

  // Program memory is deliberately not reset and only loadable while idle.
  always_ff @(posedge clk) begin
    if (prog_we && (state == S_IDLE || state == S_DONE)) begin
      mem[prog_addr] <= prog_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      pc       <= '0;
      ir       <= '0;
      wait_cnt <= '0;
      flag_z   <= 1'b0;
      flag_c   <= 1'b0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_sel  <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            pc    <= '0;
            state <= S_FETCH;
          end
        end
        S_FETCH: begin
          ir    <= mem[pc];
          state <= S_EXEC;
        end
        S_EXEC: begin
          case (kind)
            OP_LDI: begin
              regs[rd] <= imm;
              pc       <= pc + 1'b1;
              state    <= S_FETCH;
            end
            OP_BZ: begin
              pc    <= flag_z ? PC_W'(target) : pc + 1'b1;
              state <= S_FETCH;
            end
            OP_HALT: begin
              state <= S_DONE;
            end
            OP_ALU: begin
              // Operands are captured here so rd == rs1/rs2 sees pre-writeback values.
              alu_a    <= regs[rs1];
              alu_b    <= regs[rs2];
              alu_sel  <= sel;
              wait_cnt <= '0;
              state    <= S_WAIT;
            end
          endcase
        end
        S_WAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            regs[rd] <= alu_result;
            flag_z   <= alu_zero;
            flag_c   <= alu_carry;
            pc       <= pc + 1'b1;
            wait_cnt <= '0;
            state    <= S_FETCH;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy     = is_busy_state(state);
  assign done     = (state == S_DONE);
  assign dbg_data = regs[dbg_addr];

endmodule

// File: tb/tb_mini_cpu_controller.sv
// Directed self-checking bench for mini_cpu_controller with a behavioural
// latency-1 ALU (combinational on the registered operands).
module tb_mini_cpu_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [11:0] prog_data;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [1:0]  alu_sel;
  logic [7:0]  alu_result;
  logic        alu_zero;
  logic        alu_carry;
  logic        busy;
  logic        done;
  logic [3:0]  pc;
  logic        flag_z;
  logic        flag_c;
  logic [1:0]  dbg_addr;
  logic [7:0]  dbg_data;

  int tests_run    = 0;
  int tests_failed = 0;
  int cycles;
  logic [7:0] rv;

  localparam logic [11:0] HALT = 12'hC00;

  always #5 clk = ~clk;

  mini_cpu_controller #(.ALU_LATENCY(1), .PROG_DEPTH(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_data  (prog_data),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .alu_carry  (alu_carry),
    .busy       (busy),
    .done       (done),
    .pc         (pc),
    .flag_z     (flag_z),
    .flag_c     (flag_c),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data)
  );

  // External ALU: carry is the 9th sum bit for ADD and the borrow for SUB.
  always_comb begin
    {alu_carry, alu_result} = 9'h000;
    case (alu_sel)
      2'b00:   {alu_carry, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
      2'b01:   {alu_carry, alu_result} = {1'b0, alu_a} - {1'b0, alu_b};
      2'b10:   {alu_carry, alu_result} = {1'b0, alu_a & alu_b};
      default: {alu_carry, alu_result} = {1'b0, alu_a | alu_b};
    endcase
    alu_zero = (alu_result == 8'h00);
  end

  function automatic logic [11:0] ldi(input logic [1:0] rd, input logic [7:0] imm);
    return {2'b01, rd, imm};
  endfunction

  function automatic logic [11:0] alu(input logic [1:0] sel, input logic [1:0] rd,
                                      input logic [1:0] rs1, input logic [1:0] rs2);
    return {2'b00, sel, rd, rs1, rs2, 2'b00};
  endfunction

  function automatic logic [11:0] bz(input logic [3:0] t);
    return {2'b10, 6'b000000, t};
  endfunction

  task automatic check_output(input string tag, input logic [15:0] observed,
                              input logic [15:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic prog_write(input logic [3:0] a, input logic [11:0] d);
    @(negedge clk);
    prog_we   = 1'b1;
    prog_addr = a;
    prog_data = d;
    @(negedge clk);
    prog_we   = 1'b0;
  endtask

  task automatic read_reg(input logic [1:0] idx, output logic [7:0] v);
    dbg_addr = idx;
    #1;
    v = dbg_data;
  endtask

  // Pulses start (optionally with a simultaneous write) and counts edges until done.
  task automatic apply_stimulus(input logic we, input logic [3:0] a, input logic [11:0] d,
                                output int n);
    @(negedge clk);
    start     = 1'b1;
    prog_we   = we;
    prog_addr = a;
    prog_data = d;
    @(posedge clk);
    #1;
    start   = 1'b0;
    prog_we = 1'b0;
    n = 0;
    while (!done && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; prog_we = 1'b0;
    prog_addr = '0; prog_data = '0; dbg_addr = '0;

    // Reset state
    #12;
    check_output("rst_busy", 16'(busy), 16'h0);
    check_output("rst_done", 16'(done), 16'h0);
    check_output("rst_pc", 16'(pc), 16'h0);
    check_output("rst_alu_a", 16'(alu_a), 16'h0);
    check_output("rst_flags", 16'({flag_z, flag_c}), 16'h0);
    @(negedge clk);
    reset = 1'b1;

    // LDI r0,10; LDI r1,5; ADD r2,r0,r1; HALT
    prog_write(4'd0, ldi(2'd0, 8'd10));
    prog_write(4'd1, ldi(2'd1, 8'd5));
    prog_write(4'd2, alu(2'b00, 2'd2, 2'd0, 2'd1));
    prog_write(4'd3, HALT);
    apply_stimulus(1'b0, 4'd0, 12'h000, cycles);
    check_output("t1_cycles", 16'(cycles), 16'd9);
    check_output("t1_done", 16'(done), 16'h1);
    read_reg(2'd2, rv); check_output("t1_r2", 16'(rv), 16'd15);
    check_output("t1_flags", 16'({flag_z, flag_c}), 16'h0);
    check_output("t1_pc", 16'(pc), 16'd3);
    check_output("t1_alu_ops", 16'({alu_a, alu_b}), 16'h0A05);

    // SUB to zero then taken branch over LDI r3
    prog_write(4'd0, ldi(2'd0, 8'd5));
    prog_write(4'd1, ldi(2'd1, 8'd5));
    prog_write(4'd2, alu(2'b01, 2'd2, 2'd0, 2'd1));
    prog_write(4'd3, bz(4'd6));
    prog_write(4'd4, ldi(2'd3, 8'd1));
    prog_write(4'd5, HALT);
    prog_write(4'd6, HALT);
    apply_stimulus(1'b0, 4'd0, 12'h000, cycles);
    check_output("t2_cycles", 16'(cycles), 16'd11);
    read_reg(2'd2, rv); check_output("t2_r2", 16'(rv), 16'd0);
    read_reg(2'd3, rv); check_output("t2_r3", 16'(rv), 16'd0);
    check_output("t2_flag_z", 16'(flag_z), 16'h1);
    check_output("t2_flag_c", 16'(flag_c), 16'h0);
    check_output("t2_pc", 16'(pc), 16'd6);

    // ADD overflow with rd == rs1
    prog_write(4'd0, ldi(2'd0, 8'd200));
    prog_write(4'd1, ldi(2'd1, 8'd100));
    prog_write(4'd2, alu(2'b00, 2'd0, 2'd0, 2'd1));
    prog_write(4'd3, HALT);
    apply_stimulus(1'b0, 4'd0, 12'h000, cycles);
    read_reg(2'd0, rv); check_output("t3_r0", 16'(rv), 16'd44);
    check_output("t3_flags", 16'({flag_z, flag_c}), 16'b01);
    check_output("t3_alu_a_prewb", 16'(alu_a), 16'd200);

    // AND F0 & 0F
    prog_write(4'd0, ldi(2'd0, 8'hF0));
    prog_write(4'd1, ldi(2'd1, 8'h0F));
    prog_write(4'd2, alu(2'b10, 2'd2, 2'd0, 2'd1));
    apply_stimulus(1'b0, 4'd0, 12'h000, cycles);
    read_reg(2'd2, rv); check_output("t3_and_r2", 16'(rv), 16'd0);
    check_output("t3_and_flags", 16'({flag_z, flag_c}), 16'b10);
    check_output("t3_and_sel", 16'(alu_sel), 16'h2);

    // Reset asserted while the ADD is in WAIT
    prog_write(4'd0, ldi(2'd0, 8'd10));
    prog_write(4'd1, ldi(2'd1, 8'd5));
    prog_write(4'd2, alu(2'b00, 2'd2, 2'd0, 2'd1));
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check_output("t4_in_wait_busy", 16'(busy), 16'h1);
    check_output("t4_in_wait_pc", 16'(pc), 16'd2);
    #2;
    reset = 1'b0;
    #1;
    check_output("t4_async_busy", 16'(busy), 16'h0);
    check_output("t4_async_pc", 16'(pc), 16'h0);
    check_output("t4_async_alu", 16'({alu_a, alu_b}), 16'h0);
    check_output("t4_async_sel", 16'(alu_sel), 16'h0);
    read_reg(2'd2, rv); check_output("t4_r2", 16'(rv), 16'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_output("t4_idle_after", 16'({busy, done}), 16'h0);
    apply_stimulus(1'b0, 4'd0, 12'h000, cycles);
    check_output("t4_rerun_cycles", 16'(cycles), 16'd9);
    read_reg(2'd2, rv); check_output("t4_rerun_r2", 16'(rv), 16'd15);

    // start and prog_we while busy are ignored
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cycles = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    start = 1'b1; prog_we = 1'b1; prog_addr = 4'd0; prog_data = ldi(2'd0, 8'h77);
    @(posedge clk);
    #1;
    cycles++;
    start = 1'b0; prog_we = 1'b0;
    while (!done && cycles < 200) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    check_output("t5_no_restart", 16'(cycles), 16'd9);
    apply_stimulus(1'b0, 4'd0, 12'h000, cycles);
    read_reg(2'd0, rv); check_output("t5_mem_kept_r0", 16'(rv), 16'd10);

    // start together with a write in DONE: FETCH sees the new word
    apply_stimulus(1'b1, 4'd0, ldi(2'd0, 8'h21), cycles);
    check_output("t6_cycles", 16'(cycles), 16'd9);
    read_reg(2'd2, rv); check_output("t6_r2", 16'(rv), 16'h26);

    // No HALT before 15: pc wraps to 0, where a now-taken BZ reaches HALT
    prog_write(4'd0, bz(4'd3));
    prog_write(4'd1, alu(2'b01, 2'd2, 2'd0, 2'd0));
    prog_write(4'd2, bz(4'd4));
    prog_write(4'd3, HALT);
    prog_write(4'd4, alu(2'b00, 2'd2, 2'd0, 2'd1));
    for (int i = 5; i < 15; i++) begin
      prog_write(4'(i), ldi(2'd1, 8'd5));
    end
    prog_write(4'd15, alu(2'b01, 2'd2, 2'd0, 2'd0));
    apply_stimulus(1'b0, 4'd0, 12'h000, cycles);
    check_output("t7_wrap_cycles", 16'(cycles), 16'd37);
    check_output("t7_wrap_pc", 16'(pc), 16'd3);
    check_output("t7_wrap_flag_z", 16'(flag_z), 16'h1);
    read_reg(2'd2, rv); check_output("t7_wrap_r2", 16'(rv), 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mini_cpu_controller.md
MINI_CPU_CONTROLLER -- requirements
Module: mini_cpu_controller

Interface
REQ-001 Parameter ALU_LATENCY, default 1, is the number of clk edges from ALU operand/sel launch to a valid alu_result/alu_zero/alu_carry (range 1..4).
REQ-002 Parameter PROG_DEPTH, default 16, is the number of program-memory words; the pc is log2(PROG_DEPTH) bits.
REQ-003 clk  input  1  single clock; all state updates occur on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  run request; sampled in IDLE or DONE only.
REQ-006 prog_we  input  1  program-memory write enable.
REQ-007 prog_addr  input  4  program-memory write address.
REQ-008 prog_data  input  12  program-memory write data (instruction word).
REQ-009 alu_a, alu_b  output  8 each  ALU operands.
REQ-010 alu_sel  output  2  ALU op: 00 ADD, 01 SUB, 10 AND, 11 OR.
REQ-011 alu_result  input  8  registered ALU result.
REQ-012 alu_zero, alu_carry  input  1 each  registered ALU flags.
REQ-013 busy  output  1  high in FETCH, EXEC and WAIT.
REQ-014 done  output  1  high in DONE.
REQ-015 pc  output  4  current program counter.
REQ-016 flag_z, flag_c  output  1 each  architectural flags.
REQ-017 dbg_addr  input  2 / dbg_data  output  8  combinational register-file read port.

Function
REQ-018 Instruction encoding [11:10]: 00 ALU (sel=[9:8], rd=[7:6], rs1=[5:4], rs2=[3:2]); 01 LDI (rd=[9:8], imm=[7:0]); 10 BZ (target=[3:0]); 11 HALT.
REQ-019 The register file SHALL be 4 x 8 bits, written only by LDI or ALU writeback.
REQ-020 FSM states SHALL be IDLE, FETCH, EXEC, WAIT, DONE; each state lasts one cycle except WAIT (ALU_LATENCY cycles).
REQ-021 IDLE/DONE + start=1: pc<=0, go FETCH; register file and flags are preserved.
REQ-022 FETCH: ir<=mem[pc]; go EXEC.
REQ-023 EXEC LDI: rd<=imm, pc<=pc+1, go FETCH; flags unchanged.
REQ-024 EXEC BZ: pc<=target if flag_z=1, else pc<=pc+1; go FETCH.
REQ-025 EXEC HALT: pc unchanged, go DONE.
REQ-026 EXEC ALU: register alu_a<=R[rs1], alu_b<=R[rs2], alu_sel<=sel; go WAIT; these outputs are held stable until the next ALU EXEC.
REQ-027 WAIT: count ALU_LATENCY cycles; on the last cycle, rd<=alu_result, flag_z<=alu_zero, flag_c<=alu_carry, pc<=pc+1, go FETCH.
REQ-028 pc+1 SHALL wrap from 15 to 0 without fault.
REQ-029 prog_we SHALL write mem[prog_addr] only while in IDLE or DONE; writes while busy are dropped.
REQ-030 start while busy SHALL be ignored; start and prog_we together in IDLE: the write completes and FETCH reads the updated word.
REQ-031 rd equal to rs1 or rs2 SHALL use pre-writeback operand values (operands latched in EXEC).

Reset
REQ-032 reset=0 SHALL immediately force: state IDLE, pc 0, ir 0, registers 0, flags 0, alu_a/alu_b/alu_sel 0, WAIT count 0, busy 0, done 0; program memory is not reset.
REQ-033 Reset asserted mid-operation SHALL abort the instruction with no writeback; after release the block waits in IDLE for start.

Structure
REQ-034 Opcode values, ALU sel codes, state encoding and instruction field positions SHALL live in a shared package mini_cpu_pkg, also used by the ALU block.
REQ-035 Decode SHALL be one natural sub-module, mini_cpu_decode (ir -> kind, sel, rd, rs1, rs2, imm, target); the FSM, register file and program memory stay in the top.

Verification
REQ-036 Program LDI r0,10; LDI r1,5; ADD r2,r0,r1; HALT with the ALU model at latency 1, start pulsed -> done rises 9 cycles after start is sampled, r2=15, flag_z=0, flag_c=0.
REQ-037 LDI r0,5; LDI r1,5; SUB r2,r0,r1; BZ 6; LDI r3,1; HALT; (6) HALT -> r2=0, flag_z=1, r3 stays 0, final pc=6.
REQ-038 LDI r0,200; LDI r1,100; ADD r0,r0,r1; HALT -> r0=44, flag_c=1; AND 8'hF0 with 8'h0F -> 0, flag_z=1.
REQ-039 reset pulled low during WAIT of an ADD -> all outputs 0 asynchronously, rd unchanged, IDLE after release, start reruns from pc 0.
REQ-040 start and prog_we pulsed during busy -> no restart, memory unchanged; program without HALT -> pc wraps 15->0 and continues.
